// File: rtl/addsub_seq_ctrl_if.sv
// Start/done handshake bundle for the multi-byte add/sub sequencer.
// The master side issues operations; the slave side (the sequencer) returns results.
interface addsub_seq_ctrl_if #(
  parameter int BYTES = 4
);
  logic               start;
  logic               sel;
  logic [8*BYTES-1:0] a;
  logic [8*BYTES-1:0] b;
  logic               busy;
  logic               done;
  logic [8*BYTES-1:0] result;
  logic               cout;
  logic               ovf;

  modport master (
    output start, sel, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Multi-byte add/subtract sequencer: one 8-bit add/sub slice reused LSB-first,
// with the carry chained between bytes in a 1-bit register.

// 8-bit add slice; the caller pre-inverts y for subtract.
module addsub_seq_slice (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  // Single 9-bit add keeps the carry-out aligned with the sum.
  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y} + {8'h00, ci};
  end
endmodule

module addsub_seq_ctrl #(
  parameter int BYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_seq_ctrl_if.slave bus
);
  localparam int W  = 8 * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands are shifted right one byte per RUN cycle so the slice
  // always works on the low byte; no counter-indexed mux is needed.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
  } op_t;

  state_t        state, state_nxt;
  op_t           op_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  sreg;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          ovf_q;

  logic          accept;
  logic          last;
  logic [7:0]    y;
  logic [7:0]    sum;
  logic          co;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == LAST);
  assign y      = op_q.b[7:0] ^ {8{op_q.sel}};

  addsub_seq_slice u_slice (
    .x  (op_q.a[7:0]),
    .y  (y),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: START is honoured in IDLE and DONE only, ignored in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode the state register, so they are glitch-free.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Operand latch, byte walk, carry chain and final result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sreg     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      op_q.a   <= bus.a;
      op_q.b   <= bus.b;
      op_q.sel <= bus.sel;
      cnt      <= '0;
      carry    <= bus.sel;  // the +1 of two's-complement subtract
      sreg     <= '0;
    end else if (state == RUN) begin
      op_q.a <= {8'h00, op_q.a[W-1:8]};
      op_q.b <= {8'h00, op_q.b[W-1:8]};
      sreg   <= {sum, sreg[W-1:8]};
      carry  <= co;
      cnt    <= cnt + 1'b1;
      if (last) begin
        // Publish only the fully assembled word so partial bytes never show.
        result_q <= {sum, sreg[W-1:8]};
        cout_q   <= co;
        ovf_q    <= (op_q.a[7] == y[7]) && (sum[7] != op_q.a[7]);
      end
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (BYTES=4).
module tb_addsub_seq_ctrl;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_seq_ctrl_if #(.BYTES(BYTES)) bus ();

  addsub_seq_ctrl #(.BYTES(BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: full-width arithmetic in one step.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
    logic [W-1:0] yv;
    logic [W:0]   s;
    exp_t         e;
    yv       = b ^ {W{sel}};
    s        = {1'b0, a} + {1'b0, yv} + {{W{1'b0}}, sel};
    e.result = s[W-1:0];
    e.cout   = s[W];
    e.ovf    = (a[W-1] == yv[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.result = bus.result;
    o.cout   = bus.cout;
    o.ovf    = bus.ovf;
    return o;
  endfunction

  // Drive one request, push its expectation, and step past the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sel   = sel;
    exp_q.push_back(model(a, b, sel));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sel   = 1'($urandom);
  endtask

  // Bounded wait for DONE; lat = edges waited, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int   lat;
    exp_t e;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sel   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {bus.busy, bus.done, bus.result, bus.cout, bus.ovf});
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    issue('0, '0, 1'b0);
    wait_done(lat);
    total++;
    if (lat != BYTES) begin
      bad++;
      $display("FAIL reset_first_latency got=%0d want=%0d", lat, BYTES);
    end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL reset_first_result got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_add();
    int   lat;
    exp_t e;
    @(posedge clk); #1;
    issue(32'h0000_0011, 32'h0000_0011, 1'b0);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL add_busy got=%b want=1", bus.busy);
    end
    wait_done(lat);
    total++;
    if (lat != BYTES) begin
      bad++;
      $display("FAIL add_latency got=%0d want=%0d", lat, BYTES);
    end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL add_result got=%h want=%h", observed(), e);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.done, bus.busy} !== 2'b00 || observed() !== e) begin
      bad++;
      $display("FAIL add_done_pulse done=%b busy=%b res=%h want done=0 busy=0 res=%h", bus.done, bus.busy, observed(), e);
    end
  endtask

  task automatic test_sub();
    int   lat;
    exp_t e;
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat != BYTES || observed() !== e) begin
      bad++;
      $display("FAIL sub got=%h lat=%0d want=%h lat=%0d", observed(), lat, e, BYTES);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_ripple();
    int   lat;
    exp_t e;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat != BYTES || observed() !== e) begin
      bad++;
      $display("FAIL ripple got=%h lat=%0d want=%h lat=%0d", observed(), lat, e, BYTES);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   extra;
    exp_t e;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    // Mid-RUN START with other operands must be dropped.
    bus.start = 1'b1;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h0F0F_0F0F;
    bus.sel   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    total++;
    if (lat != BYTES - 2) begin
      bad++;
      $display("FAIL ovf_latency got=%0d want=%0d", lat, BYTES - 2);
    end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL ovf_result got=%h want=%h", observed(), e);
    end
    // START during DONE starts the next operation at once.
    bus.start = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd3;
    bus.sel   = 1'b1;
    exp_q.push_back(model(32'd5, 32'd3, 1'b1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if ({bus.done, bus.busy} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_accept done=%b busy=%b want done=0 busy=1", bus.done, bus.busy);
    end
    wait_done(lat);
    total++;
    if (lat != BYTES) begin
      bad++;
      $display("FAIL b2b_latency got=%0d want=%0d", lat + 1, BYTES + 1);
    end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL b2b_result got=%h want=%h", observed(), e);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL no_queued_start done_count=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    int   extra;
    exp_t e;
    issue(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0", {bus.busy, bus.done, bus.result, bus.cout, bus.ovf});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done active_cycles=%0d want=0", extra);
    end
    issue(32'h0100_0000, 32'h0100_0000, 1'b0);
    wait_done(lat);
    e = exp_q.pop_front();
    total++;
    if (lat != BYTES || observed() !== e) begin
      bad++;
      $display("FAIL reset_mid_restart got=%h lat=%0d want=%h lat=%0d", observed(), lat, e, BYTES);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int   lat;
    exp_t e;
    for (int n = 0; n < 8; n++) begin
      issue($urandom, $urandom, 1'($urandom));
      wait_done(lat);
      e = exp_q.pop_front();
      total++;
      if (lat != BYTES || observed() !== e) begin
        bad++;
        $display("FAIL random_%0d got=%h lat=%0d want=%h lat=%0d", n, observed(), lat, e, BYTES);
      end
    end
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sel   = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_carry_ripple();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
